// File: rtl/master_0_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : master_0_st_packet_arbiter
// Description : Packet-level round-robin arbiter merging NUM_IN Avalon-ST
//               sources into one stream. A source is granted at a packet
//               boundary and keeps the grant until its EOP beat transfers.
//               Each grant costs one idle arbitration cycle.
// Ports       : clk, reset_n (sync, active-low)
//               in_valid/in_data/in_startofpacket/in_endofpacket/in_ready
//                   per-source sink side, source i at bit i / data slice i
//               out_valid/out_ready/out_data/out_channel/out_startofpacket/
//               out_endofpacket  merged source side, out_channel = grant
//               pkt_count  packets forwarded, wraps at 2^16
// Parameters  : NUM_IN (2..16), DATA_W
// Revision    : 1.0  initial release
// ============================================================================
module master_0_st_packet_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [7:0]               out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [15:0]              pkt_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_grant;
    logic [3:0]         w_grant_nxt;
    logic [3:0]         r_last;
    logic [3:0]         w_last_nxt;
    logic [15:0]        r_pkt_count;
    logic [15:0]        w_pkt_count_nxt;

    logic               w_sel_valid;
    logic               w_sel_sop;
    logic               w_sel_eop;
    logic [DATA_W-1:0]  w_sel_data;

    logic               w_req_found;
    logic [3:0]         w_req_idx;
    logic [15:0]        w_valid_ext;

    // Zero-extended so a 4-bit candidate index always selects in range.
    assign w_valid_ext = 16'(in_valid);

    // Granted-source mux.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_grant == 4'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_sop   = in_startofpacket[i];
                w_sel_eop   = in_endofpacket[i];
                w_sel_data  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin search starting at (last + 1) mod NUM_IN with wrap. Since
    // r_last < NUM_IN and the offset is at most NUM_IN, a single subtraction
    // folds the candidate back into range.
    always_comb begin
        logic [4:0] w_cand;
        w_req_found = 1'b0;
        w_req_idx   = r_last;
        w_cand      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            w_cand = 5'(r_last) + 5'(k);
            if (w_cand >= 5'(NUM_IN)) begin
                w_cand = w_cand - 5'(NUM_IN);
            end
            if (!w_req_found && w_valid_ext[w_cand[3:0]]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_cand[3:0];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_last_nxt        = r_last;
        w_pkt_count_nxt   = r_pkt_count;
        out_valid         = 1'b0;
        out_data          = '0;
        out_channel       = 8'd0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        in_ready          = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_req_idx;
                end
            end
            ST_BUSY: begin
                out_valid         = w_sel_valid;
                out_data          = w_sel_data;
                out_startofpacket = w_sel_sop;
                out_endofpacket   = w_sel_eop;
                out_channel       = {4'd0, r_grant};
                in_ready          = NUM_IN'(out_ready) << r_grant;
                // Only the EOP beat actually accepted ends the packet.
                if (w_sel_valid && out_ready && w_sel_eop) begin
                    w_state_nxt     = ST_IDLE;
                    w_last_nxt      = r_grant;
                    w_pkt_count_nxt = r_pkt_count + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset wins over everything, including a same-cycle EOP transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= 4'd0;
            r_last      <= 4'(NUM_IN - 1);
            r_pkt_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_last      <= w_last_nxt;
            r_pkt_count <= w_pkt_count_nxt;
        end
    end

    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_master_0_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_master_0_st_packet_arbiter
// Description : Scoreboard bench for the packet arbiter. Per-source beat
//               queues feed the DUT; expected merged beats are queued in
//               hand-derived arbitration order and a monitor pops/compares
//               each accepted output beat.
// Revision    : 1.0  initial release
// ============================================================================
module tb_master_0_st_packet_arbiter;

    localparam int NUM_IN = 4;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_IN-1:0]        in_valid = '0;
    logic [NUM_IN*DATA_W-1:0] in_data = '0;
    logic [NUM_IN-1:0]        in_startofpacket = '0;
    logic [NUM_IN-1:0]        in_endofpacket = '0;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [7:0]               out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic [15:0]              pkt_count;

    beat_t             src_q[NUM_IN][$];
    exp_t              exp_q[$];
    logic [NUM_IN-1:0] gap = '0;
    logic [NUM_IN-1:0] xfer;
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                prev_cyc = 0;
    bit                has_prev = 0;
    bit                check_spacing = 0;

    master_0_st_packet_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_ready         (in_ready),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_channel      (out_channel),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .pkt_count        (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic load(input int s, input int n, input logic [7:0] base, input bit first_sop);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d   = base + 8'(k);
            b.sop = (k == 0) && first_sop;
            b.eop = (k == n - 1);
            src_q[s].push_back(b);
        end
    endtask

    // Queue the first 'cnt' beats of an n-beat packet from source s.
    task automatic expect_pkt(input int s, input int n, input logic [7:0] base,
                              input bit first_sop, input int cnt);
        exp_t e;
        for (int k = 0; k < cnt; k++) begin
            e.ch  = 8'(s);
            e.d   = base + 8'(k);
            e.sop = (k == 0) && first_sop;
            e.eop = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk); #2;
        end
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #4;
    endtask

    // Source models: a beat leaves its queue only when accepted at an edge
    // with reset released; the head beat is held until then.
    initial begin
        forever begin
            @(negedge clk); #1;
            xfer = in_valid & in_ready & {NUM_IN{reset_n}};
            @(posedge clk); #3;
            for (int i = 0; i < NUM_IN; i++) begin
                if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && !gap[i]) begin
                    in_valid[i]               = 1'b1;
                    in_data[i*DATA_W +: DATA_W] = src_q[i][0].d;
                    in_startofpacket[i]       = src_q[i][0].sop;
                    in_endofpacket[i]         = src_q[i][0].eop;
                end else begin
                    in_valid[i]               = 1'b0;
                    in_data[i*DATA_W +: DATA_W] = '0;
                    in_startofpacket[i]       = 1'b0;
                    in_endofpacket[i]         = 1'b0;
                end
            end
        end
    end

    // Monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (reset_n && out_valid) begin
                chk("in_ready_onehot", 32'(in_ready), 32'(NUM_IN'(out_ready) << out_channel));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual=ch%0d/%0h required=none", out_channel, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 32'({out_channel, out_data, out_startofpacket, out_endofpacket}), 32'(e));
                    end
                    if (check_spacing) begin
                        if (has_prev) chk("beat_spacing", 32'(cyc - prev_cyc), 32'd2);
                        has_prev = 1;
                        prev_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;

        // Two sources pending while in reset; outputs must stay quiet.
        load(0, 3, 8'h10, 1);
        load(2, 3, 8'h20, 1);
        expect_pkt(0, 3, 8'h10, 1, 3);
        expect_pkt(2, 3, 8'h20, 1, 3);
        repeat (3) begin
            @(negedge clk); #2;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_pkt_count", 32'(pkt_count), 0);
        end
        @(posedge clk); #4;
        reset_n = 1'b1;
        @(negedge clk); #2;
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_in_ready", 32'(in_ready), 0);
        wait_drain(60, "drain_two_src");
        chk("cnt_two_src", 32'(pkt_count), 2);

        // All four sources, two single-beat packets each, from fresh reset.
        @(posedge clk); #4; reset_n = 1'b0;
        @(posedge clk); #4; reset_n = 1'b1;
        chk("cnt_after_reset", 32'(pkt_count), 0);
        for (int i = 0; i < NUM_IN; i++) begin
            load(i, 1, 8'h40 + 8'(i * 16), 1);
            load(i, 1, 8'h41 + 8'(i * 16), 1);
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NUM_IN; i++)
                expect_pkt(i, 1, 8'h40 + 8'(i * 16 + k), 1, 1);
        has_prev = 0;
        check_spacing = 1;
        wait_drain(60, "drain_rr");
        check_spacing = 0;
        chk("cnt_rr", 32'(pkt_count), 8);

        // src1 long packet; src0 shows up on beat 2 and must wait.
        load(1, 5, 8'h60, 1);
        expect_pkt(1, 5, 8'h60, 1, 5);
        expect_pkt(0, 2, 8'h70, 1, 2);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #4;
            if (src_q[1].size() == 4) break;
        end
        chk("src1_first_beat", 32'(src_q[1].size()), 4);
        load(0, 2, 8'h70, 1);
        wait_drain(60, "drain_no_preempt");
        chk("cnt_no_preempt", 32'(pkt_count), 10);

        // src3 with out_ready toggling and a valid gap; src1 joins mid-packet.
        load(3, 6, 8'h80, 1);
        expect_pkt(3, 6, 8'h80, 1, 6);
        expect_pkt(1, 1, 8'h90, 1, 1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            out_ready = (c % 2 == 0);
            gap[3]    = (c == 4 || c == 5);
            if (c == 3) load(1, 1, 8'h90, 1);
            @(negedge clk); #2;
            if (c == 4) begin
                chk("gap_out_valid", 32'(out_valid), 0);
                chk("gap_in_ready0", 32'(in_ready[1]), 0);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        gap       = '0;
        wait_drain(80, "drain_backpressure");
        chk("cnt_backpressure", 32'(pkt_count), 12);

        // Reset lands on beat 2 of a 4-beat src2 packet.
        load(2, 4, 8'hA0, 1);
        expect_pkt(2, 4, 8'hA0, 1, 1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #4;
            if (src_q[2].size() == 3) break;
        end
        reset_n = 1'b0;
        @(posedge clk); #4;
        chk("midrst_cnt", 32'(pkt_count), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        src_q[2].delete();
        @(posedge clk); #4;
        reset_n = 1'b1;
        chk("midrst_partial_beats", 32'(exp_q.size()), 0);
        load(0, 1, 8'hB0, 1);
        load(2, 1, 8'hB8, 1);
        expect_pkt(0, 1, 8'hB0, 1, 1);
        expect_pkt(2, 1, 8'hB8, 1, 1);
        wait_drain(40, "drain_after_midrst");
        chk("cnt_after_midrst", 32'(pkt_count), 2);

        // Counter wrap: preload near the top rather than sending 65535
        // packets; the final packet also starts without SOP.
        @(negedge clk);
        force dut.r_pkt_count = 16'hFFFF;
        #1;
        release dut.r_pkt_count;
        load(1, 1, 8'hC0, 0);
        expect_pkt(1, 1, 8'hC0, 0, 1);
        wait_drain(40, "drain_wrap");
        chk("cnt_wrap", 32'(pkt_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/master_0_st_packet_arbiter.md
MASTER_0_ST_PACKET_ARBITER -- requirements
Module: master_0_st_packet_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of Avalon-ST source ports; legal range 2..16.
REQ-002 Parameter DATA_W, default 8, symbol data width per port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  NUM_IN  per-source valid; bit i belongs to source i.
REQ-006 in_data  input  NUM_IN*DATA_W  per-source data; source i at bits [i*DATA_W +: DATA_W].
REQ-007 in_startofpacket  input  NUM_IN  per-source SOP.
REQ-008 in_endofpacket  input  NUM_IN  per-source EOP.
REQ-009 in_ready  output  NUM_IN  per-source ready.
REQ-010 out_ready  input  1  downstream ready.
REQ-011 out_valid  output  1  merged stream valid.
REQ-012 out_data  output  DATA_W  merged stream data.
REQ-013 out_channel  output  8  index of granted source, zero-extended.
REQ-014 out_startofpacket  output  1  merged SOP.
REQ-015 out_endofpacket  output  1  merged EOP.
REQ-016 pkt_count  output  16  count of packets forwarded, wraps.

Function
REQ-017 Block SHALL implement two states: IDLE and BUSY, plus grant register (4 bits) and last-served pointer.
REQ-018 Beat transfer SHALL be defined as out_valid & out_ready in the same cycle; zero ready-latency.
REQ-019 In IDLE: out_valid=0, in_ready all 0, out_data/out_channel/SOP/EOP driven 0.
REQ-020 In IDLE with any in_valid bit set: next cycle SHALL enter BUSY, grant = first set bit searching from (last+1) mod NUM_IN upward with wrap; one-cycle arbitration bubble.
REQ-021 In IDLE with in_valid all 0: remain IDLE, grant and last unchanged.
REQ-022 In BUSY: out_valid, out_data, out_startofpacket, out_endofpacket SHALL equal granted source's signals combinationally; out_channel = grant.
REQ-023 In BUSY: in_ready[grant] = out_ready; all other in_ready bits = 0.
REQ-024 Grant SHALL be held from grant cycle until EOP beat transfers; no re-arbitration mid-packet regardless of other requests.
REQ-025 Granted source deasserting in_valid mid-packet: stay BUSY, out_valid=0, grant held.
REQ-026 out_ready low: stay BUSY, no state change; source holds data per Avalon-ST.
REQ-027 On EOP beat transfer: next state IDLE, last = grant, pkt_count = pkt_count + 1 mod 2^16.
REQ-028 Single-beat packet (SOP and EOP same beat) SHALL follow REQ-027 identically.
REQ-029 Granted source presenting a beat without SOP as first beat SHALL be forwarded unmodified; no checking or dropping.
REQ-030 Non-granted valid sources SHALL be stalled, never dropped; round-robin guarantees each requester service within NUM_IN packets.

Reset
REQ-031 reset_n low at rising edge: state=IDLE, grant=0, last=NUM_IN-1 (source 0 highest priority next), pkt_count=0.
REQ-032 Reset SHALL take priority over all other events, including mid-packet and same-cycle EOP transfer; in-flight packet abandoned, count not incremented.
REQ-033 During reset cycles and the first cycle after, out_valid=0 and in_ready all 0.

Verification
REQ-034 After reset, src0 and src2 valid with 3-beat packets, out_ready=1 -> bubble, src0 beats out_channel=0, bubble, src2 beats out_channel=2; pkt_count=2.
REQ-035 All 4 sources continuously sending 1-beat packets, out_ready=1 -> channel order 0,1,2,3,0,...; each beat separated by one idle cycle; pkt_count increments per packet.
REQ-036 src1 5-beat packet, src0 asserts valid on beat 2 -> src1 completes all 5 beats uninterrupted, then src0 served; in_ready[0]=0 throughout src1 packet.
REQ-037 out_ready toggled 1,0,1,0 during src3 packet -> each beat transferred exactly once, no duplication, grant stays 3; src3 valid gap mid-packet -> out_valid=0, grant held.
REQ-038 Assert reset_n=0 on beat 2 of 4-beat src2 packet -> next cycle IDLE, pkt_count=0; subsequent requests from src0 and src2 -> src0 granted first.
REQ-039 Force pkt_count to 16'hFFFF via 65535 packets, send one more -> pkt_count=16'h0000.
